fetch_decoder: RTL and testbench

- Front-end responder to the dispatcher's fetch request (DPDC_ask_IF).
- Owns the PC. Fetches one 32-bit word from the instruction cache and decodes it into internal opcode numbering, register fields and a sign-extended immediate.
- Predicts conditional branches with a 2-bit BHT and delivers the result as a one-cycle DCDP_en pulse.
- Sits between ICache and Dispatcher; the RoB redirects it on mispredict.

---
 rtl/fetch_decoder_pkg.sv | 69 ++++++
 rtl/fetch_decoder_bht.sv | 27 ++
 rtl/fetch_decoder.sv | 103 ++++++++++
 tb/tb_fetch_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decoder_pkg.sv
// fetch_decoder_pkg: internal opcode numbering, RV32I encoding constants and decode helpers
package fetch_decoder_pkg;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} fd_state_t;
  localparam logic [6:0] OP_ILLEGAL = 7'd0, OP_LUI = 7'd1, OP_AUIPC = 7'd2, OP_JAL = 7'd3, OP_JALR = 7'd4;
  localparam logic [6:0] OP_BEQ = 7'd5, OP_BLT = 7'd7, OP_BGEU = 7'd10;
  localparam logic [6:0] OP_LB = 7'd11, OP_LBU = 7'd14, OP_SB = 7'd16, OP_SW = 7'd18;
  localparam logic [6:0] OP_ADDI = 7'd19, OP_SLTI = 7'd20, OP_SLTIU = 7'd21, OP_XORI = 7'd22;
  localparam logic [6:0] OP_ORI = 7'd23, OP_ANDI = 7'd24, OP_SLLI = 7'd25, OP_SRLI = 7'd26, OP_SRAI = 7'd27;
  localparam logic [6:0] OP_ADD = 7'd28, OP_SUB = 7'd29, OP_SLL = 7'd30, OP_SLT = 7'd31, OP_SLTU = 7'd32;
  localparam logic [6:0] OP_XOR = 7'd33, OP_SRL = 7'd34, OP_SRA = 7'd35, OP_OR = 7'd36, OP_ANDD = 7'd37;
  localparam logic [6:0] RV_LUI = 7'b0110111, RV_AUIPC = 7'b0010111, RV_JAL = 7'b1101111;
  localparam logic [6:0] RV_JALR = 7'b1100111, RV_BRANCH = 7'b1100011, RV_LOAD = 7'b0000011;
  localparam logic [6:0] RV_STORE = 7'b0100011, RV_OPIMM = 7'b0010011, RV_OP = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

  function automatic logic [6:0] decode_op(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [6:0] op;
    f3 = ins[14:12];
    f7 = ins[31:25];
    op = OP_ILLEGAL;
    case (ins[6:0])
      RV_LUI:    op = OP_LUI;
      RV_AUIPC:  op = OP_AUIPC;
      RV_JAL:    op = OP_JAL;
      RV_JALR:   op = (f3 == 3'd0) ? OP_JALR : OP_ILLEGAL;
      RV_BRANCH: op = f3[2] ? OP_BLT + 7'(f3[1:0]) : (f3[1] ? OP_ILLEGAL : OP_BEQ + 7'(f3[0]));
      RV_LOAD:   op = (f3 < 3'd3) ? OP_LB + 7'(f3) : (f3 == 3'd4 || f3 == 3'd5) ? OP_LBU + 7'(f3[0]) : OP_ILLEGAL;
      RV_STORE:  op = (f3 < 3'd3) ? OP_SB + 7'(f3) : OP_ILLEGAL;
      RV_OPIMM:
        case (f3)
          3'd0: op = OP_ADDI;
          3'd1: op = (f7 == F7_BASE) ? OP_SLLI : OP_ILLEGAL;
          3'd2: op = OP_SLTI;
          3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI;
          3'd5: op = (f7 == F7_BASE) ? OP_SRLI : (f7 == F7_ALT) ? OP_SRAI : OP_ILLEGAL;
          3'd6: op = OP_ORI;
          default: op = OP_ANDI;
        endcase
      RV_OP:
        case (f3)
          3'd0: op = (f7 == F7_BASE) ? OP_ADD : (f7 == F7_ALT) ? OP_SUB : OP_ILLEGAL;
          3'd1: op = (f7 == F7_BASE) ? OP_SLL : OP_ILLEGAL;
          3'd2: op = (f7 == F7_BASE) ? OP_SLT : OP_ILLEGAL;
          3'd3: op = (f7 == F7_BASE) ? OP_SLTU : OP_ILLEGAL;
          3'd4: op = (f7 == F7_BASE) ? OP_XOR : OP_ILLEGAL;
          3'd5: op = (f7 == F7_BASE) ? OP_SRL : (f7 == F7_ALT) ? OP_SRA : OP_ILLEGAL;
          3'd6: op = (f7 == F7_BASE) ? OP_OR : OP_ILLEGAL;
          default: op = (f7 == F7_BASE) ? OP_ANDD : OP_ILLEGAL;
        endcase
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  // shifts carry a zero-extended shamt; R-type and illegal words carry no immediate
  function automatic logic [31:0] decode_imm(input logic [31:0] ins, input logic [6:0] op);
    return (op == OP_ILLEGAL || op >= OP_ADD) ? 32'd0
      : (op == OP_LUI || op == OP_AUIPC) ? {ins[31:12], 12'd0}
      : (op == OP_JAL) ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}
      : (op >= OP_BEQ && op <= OP_BGEU) ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}
      : (op >= OP_SB && op <= OP_SW) ? {{20{ins[31]}}, ins[31:25], ins[11:7]}
      : (op >= OP_SLLI && op <= OP_SRAI) ? {27'd0, ins[24:20]}
      : {{20{ins[31]}}, ins[31:20]};
  endfunction
endpackage

// File: rtl/fetch_decoder_bht.sv
// bht_predictor: 2-bit saturating branch history table, async read, sync update
module bht_predictor #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_ctr,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);
  logic [1:0] r_ctr [2**IDX_W];
  logic [1:0] w_cur;
  logic [1:0] w_nxt;
  assign o_ctr = r_ctr[i_rd_idx];
  assign w_cur = r_ctr[i_upd_idx];
  assign w_nxt = i_upd_taken ? ((w_cur == 2'b11) ? w_cur : w_cur + 2'd1)
                             : ((w_cur == 2'b00) ? w_cur : w_cur - 2'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) r_ctr[i] <= 2'b01;
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= w_nxt;
    end
  end
endmodule

// File: rtl/fetch_decoder.sv
// fetch_decoder: owns the PC, fetches one word per dispatcher request, decodes and predicts it
module fetch_decoder
  import fetch_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int BHT_IDX_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  DPDC_ask_IF,
  output logic                  DCDP_en,
  output logic [ADDR_WIDTH-1:0] DCDP_pc,
  output logic [6:0]            DCDP_opcode,
  output logic [4:0]            DCDP_rs1,
  output logic [4:0]            DCDP_rs2,
  output logic [4:0]            DCDP_rd,
  output logic [31:0]           DCDP_imm,
  output logic                  DCDP_predict_result,
  output logic                  DCIC_en,
  output logic [ADDR_WIDTH-1:0] DCIC_addr,
  input  logic                  ICDC_en,
  input  logic [31:0]           ICDC_inst,
  input  logic                  RoBDC_pre_judge,
  input  logic [ADDR_WIDTH-1:0] RoBDC_new_pc,
  input  logic                  RoBDC_br_en,
  input  logic [ADDR_WIDTH-1:0] RoBDC_br_pc,
  input  logic                  RoBDC_br_taken
);
  fd_state_t r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [6:0] w_op;
  logic [31:0] w_imm;
  logic [1:0] w_ctr;
  logic w_is_br, w_pred, w_unused_br_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  assign w_op = decode_op(ICDC_inst);
  assign w_imm = decode_imm(ICDC_inst, w_op);
  assign w_is_br = (w_op >= OP_BEQ) && (w_op <= OP_BGEU);
  assign w_pred = w_is_br ? w_ctr[1] : (w_op == OP_JAL);
  assign w_next_pc = w_pred ? r_pc + ADDR_WIDTH'(w_imm) : r_pc + ADDR_WIDTH'(4);
  assign w_unused_br_pc = ^{RoBDC_br_pc[ADDR_WIDTH-1:BHT_IDX_WIDTH+2], RoBDC_br_pc[1:0]};

  // lookup reads the stored counter, so a same-cycle update is seen only by later fetches
  bht_predictor #(.IDX_W(BHT_IDX_WIDTH)) u_bht (
    .clk(Sys_clk),
    .rst(Sys_rst),
    .i_rd_idx(r_pc[BHT_IDX_WIDTH+1:2]),
    .o_ctr(w_ctr),
    .i_upd_en(Sys_rdy & RoBDC_br_en),
    .i_upd_idx(RoBDC_br_pc[BHT_IDX_WIDTH+1:2]),
    .i_upd_taken(RoBDC_br_taken)
  );

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      r_state <= S_IDLE;
      r_pc <= RESET_PC;
      DCIC_en <= 1'b0;
      DCIC_addr <= '0;
      DCDP_en <= 1'b0;
      DCDP_pc <= '0;
      DCDP_opcode <= '0;
      DCDP_rs1 <= '0;
      DCDP_rs2 <= '0;
      DCDP_rd <= '0;
      DCDP_imm <= '0;
      DCDP_predict_result <= 1'b0;
    end else if (!RoBDC_pre_judge) begin
      r_pc <= RoBDC_new_pc;
      r_state <= S_IDLE;
      DCIC_en <= 1'b0;
      DCDP_en <= 1'b0;
    end else if (Sys_rdy) begin
      case (r_state)
        S_IDLE: if (DPDC_ask_IF) begin
          DCIC_en <= 1'b1;
          DCIC_addr <= r_pc;
          r_state <= S_FETCH;
        end
        S_FETCH: if (ICDC_en) begin
          DCIC_en <= 1'b0;
          DCDP_en <= 1'b1;
          DCDP_pc <= r_pc;
          DCDP_opcode <= w_op;
          DCDP_rs1 <= ICDC_inst[19:15];
          DCDP_rs2 <= ICDC_inst[24:20];
          DCDP_rd <= ICDC_inst[11:7];
          DCDP_imm <= w_imm;
          DCDP_predict_result <= w_pred;
          r_pc <= w_next_pc;
          r_state <= S_DONE;
        end
        S_DONE: begin
          DCDP_en <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_decoder.sv
// tb_fetch_decoder: directed and randomized fetch/decode/predict checks against a mnemonic-level model
module tb_fetch_decoder;
  typedef enum {FU, FJ, FI, FB, FS, FR, FH} fmt_t;
  logic clk = 0, rst = 1, rdy = 1, ask = 0, ic_en = 0, pj = 1, br_en = 0, br_taken = 0;
  logic [31:0] ic_inst = 0, new_pc = 0, br_pc = 0;
  logic DCDP_en, DCDP_predict_result, DCIC_en;
  logic [31:0] DCDP_pc, DCDP_imm, DCIC_addr;
  logic [6:0] DCDP_opcode;
  logic [4:0] DCDP_rs1, DCDP_rs2, DCDP_rd;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_pc;
  int bht [64];
  fmt_t fmt [38];
  logic [6:0] opc [38];
  logic [2:0] f3 [38];
  logic [6:0] f7 [38];
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] oi_f3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic [2:0] r_f3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};

  fetch_decoder dut (
    .Sys_clk(clk), .Sys_rst(rst), .Sys_rdy(rdy), .DPDC_ask_IF(ask),
    .DCDP_en(DCDP_en), .DCDP_pc(DCDP_pc), .DCDP_opcode(DCDP_opcode), .DCDP_rs1(DCDP_rs1),
    .DCDP_rs2(DCDP_rs2), .DCDP_rd(DCDP_rd), .DCDP_imm(DCDP_imm), .DCDP_predict_result(DCDP_predict_result),
    .DCIC_en(DCIC_en), .DCIC_addr(DCIC_addr), .ICDC_en(ic_en), .ICDC_inst(ic_inst),
    .RoBDC_pre_judge(pj), .RoBDC_new_pc(new_pc), .RoBDC_br_en(br_en), .RoBDC_br_pc(br_pc),
    .RoBDC_br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void bht_upd(input int i, input bit t);
    bht[i] = t ? ((bht[i] == 3) ? 3 : bht[i] + 1) : ((bht[i] == 0) ? 0 : bht[i] - 1);
  endfunction

  function automatic logic [31:0] enc(input int k, input logic [31:0] imm, input logic [4:0] rd, rs1, rs2);
    case (fmt[k])
      FU: return {imm[31:12], rd, opc[k]};
      FJ: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc[k]};
      FB: return {imm[12], imm[10:5], rs2, rs1, f3[k], imm[4:1], imm[11], opc[k]};
      FS: return {imm[11:5], rs2, rs1, f3[k], imm[4:0], opc[k]};
      FR: return {f7[k], rs2, rs1, f3[k], rd, opc[k]};
      FH: return {f7[k], imm[4:0], rs1, f3[k], rd, opc[k]};
      default: return {imm[11:0], rs1, f3[k], rd, opc[k]};
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input int k);
    logic [31:0] r;
    r = $urandom;
    case (fmt[k])
      FU: return {r[31:12], 12'd0};
      FJ: return {{11{r[20]}}, r[20:1], 1'b0};
      FB: return {{19{r[12]}}, r[12:1], 1'b0};
      FR: return 32'd0;
      FH: return {27'd0, r[4:0]};
      default: return {{20{r[11]}}, r[11:0]};
    endcase
  endfunction

  task automatic br_update(input logic [31:0] pc, input bit t);
    br_en = 1; br_pc = pc; br_taken = t;
    @(negedge clk);
    br_en = 0;
    bht_upd(int'(pc[7:2]), t);
  endtask

  task automatic flush_to(input logic [31:0] p);
    pj = 0; new_pc = p;
    @(negedge clk);
    pj = 1; m_pc = p;
  endtask

  // one request/response/pulse round trip; the model predicts from the counter before any same-cycle update
  task automatic fetch(input logic [31:0] ins, input int k, input logic [31:0] imm, input bit upd, input bit skip_req);
    int idx;
    bit pred, tk, is_br;
    logic [31:0] nxt;
    idx = int'(m_pc[7:2]);
    is_br = (k >= 5 && k <= 10);
    pred = is_br ? (bht[idx] >= 2) : (k == 3);
    nxt = pred ? m_pc + imm : m_pc + 32'd4;
    ask = 1;
    if (!skip_req) begin
      @(negedge clk);
      chk("req_en", 32'(DCIC_en), 32'd1);
      chk("req_addr", DCIC_addr, m_pc);
    end
    ic_en = 1; ic_inst = ins; tk = 1'($urandom);
    if (upd) begin br_en = 1; br_pc = m_pc; br_taken = tk; end
    @(negedge clk);
    ic_en = 0; br_en = 0;
    if (upd) bht_upd(idx, tk);
    chk("dcdp_en", 32'(DCDP_en), 32'd1);
    chk("req_drop", 32'(DCIC_en), 32'd0);
    chk("dcdp_pc", DCDP_pc, m_pc);
    chk("opcode", 32'(DCDP_opcode), 32'(k));
    chk("imm", DCDP_imm, imm);
    chk("rd", 32'(DCDP_rd), 32'(ins[11:7]));
    chk("rs1", 32'(DCDP_rs1), 32'(ins[19:15]));
    chk("rs2", 32'(DCDP_rs2), 32'(ins[24:20]));
    chk("predict", 32'(DCDP_predict_result), 32'(pred));
    @(negedge clk);
    chk("pulse_end", 32'(DCDP_en), 32'd0);
    ask = 0;
    m_pc = nxt;
  endtask

  initial begin
    for (int i = 0; i < 38; i++) begin fmt[i] = FI; opc[i] = 7'h13; f3[i] = 0; f7[i] = 0; end
    fmt[1] = FU; opc[1] = 7'h37; fmt[2] = FU; opc[2] = 7'h17;
    fmt[3] = FJ; opc[3] = 7'h6F; opc[4] = 7'h67;
    for (int i = 0; i < 6; i++) begin fmt[5+i] = FB; opc[5+i] = 7'h63; f3[5+i] = br_f3[i]; end
    for (int i = 0; i < 5; i++) begin opc[11+i] = 7'h03; f3[11+i] = ld_f3[i]; end
    for (int i = 0; i < 3; i++) begin fmt[16+i] = FS; opc[16+i] = 7'h23; f3[16+i] = 3'(i); end
    for (int i = 0; i < 6; i++) f3[19+i] = oi_f3[i];
    fmt[25] = FH; f3[25] = 3'd1; fmt[26] = FH; f3[26] = 3'd5; fmt[27] = FH; f3[27] = 3'd5; f7[27] = 7'h20;
    for (int i = 0; i < 10; i++) begin fmt[28+i] = FR; opc[28+i] = 7'h33; f3[28+i] = r_f3[i]; end
    f7[29] = 7'h20; f7[35] = 7'h20;
    for (int i = 0; i < 64; i++) bht[i] = 1;
    m_pc = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_dcic_en", 32'(DCIC_en), 32'd0);
    chk("rst_dcdp_en", 32'(DCDP_en), 32'd0);
    chk("rst_dcic_addr", DCIC_addr, 32'd0);
    chk("rst_opcode", 32'(DCDP_opcode), 32'd0);
    fetch(32'h00500093, 19, 32'd5, 0, 0);
    fetch(32'h008000EF, 3, 32'd8, 0, 0);
    flush_to(32'h10);
    fetch(32'hFE000EE3, 5, 32'hFFFFFFFC, 0, 0);
    br_update(32'h10, 1);
    br_update(32'h10, 1);
    flush_to(32'h10);
    fetch(32'hFE000EE3, 5, 32'hFFFFFFFC, 0, 0);
    ask = 1;
    @(negedge clk);
    chk("fl_req_en", 32'(DCIC_en), 32'd1);
    chk("fl_req_addr", DCIC_addr, 32'hC);
    pj = 0; new_pc = 32'h100; ask = 0;
    @(negedge clk);
    pj = 1;
    chk("fl_drop", 32'(DCIC_en), 32'd0);
    ic_en = 1; ic_inst = 32'h00500093;
    @(negedge clk);
    ic_en = 0;
    chk("fl_no_dcdp", 32'(DCDP_en), 32'd0);
    @(negedge clk);
    chk("fl_no_dcdp2", 32'(DCDP_en), 32'd0);
    chk("fl_no_req", 32'(DCIC_en), 32'd0);
    m_pc = 32'h100;
    fetch(32'h00500093, 19, 32'd5, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("hs_idle", 32'(DCIC_en), 32'd0);
    end
    ask = 1;
    @(negedge clk);
    chk("frz_req", 32'(DCIC_en), 32'd1);
    rdy = 0; br_en = 1; br_pc = m_pc; br_taken = 1;
    repeat (3) begin
      @(negedge clk);
      chk("frz_en", 32'(DCIC_en), 32'd1);
      chk("frz_addr", DCIC_addr, m_pc);
      chk("frz_dcdp", 32'(DCDP_en), 32'd0);
    end
    rdy = 1; br_en = 0;
    fetch(enc(5, 32'd8, 5'd0, 5'd1, 5'd2), 5, 32'd8, 0, 1);
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [31:0] imm, ins;
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 10)) : int'($urandom_range(0, 37));
      if (k == 0) begin
        ins = $urandom | 32'h7F;
        imm = 0;
      end else begin
        imm = rand_imm(k);
        ins = enc(k, imm, 5'($urandom), 5'($urandom), 5'($urandom));
      end
      if ($urandom_range(0, 5) == 0) flush_to({24'd0, 6'($urandom), 2'b00});
      if ($urandom_range(0, 3) == 0) br_update(m_pc + 32'($urandom_range(0, 2) * 4), 1'($urandom));
      fetch(ins, k, imm, $urandom_range(0, 3) == 0, 0);
    end
    br_update(32'h10, 1);
    br_update(32'h10, 1);
    ask = 1;
    @(negedge clk);
    chk("ar_req", 32'(DCIC_en), 32'd1);
    #2 rst = 1;
    #1;
    chk("ar_dcic_en", 32'(DCIC_en), 32'd0);
    chk("ar_dcic_addr", DCIC_addr, 32'd0);
    chk("ar_dcdp_en", 32'(DCDP_en), 32'd0);
    chk("ar_dcdp_pc", DCDP_pc, 32'd0);
    chk("ar_imm", DCDP_imm, 32'd0);
    chk("ar_pred", 32'(DCDP_predict_result), 32'd0);
    ask = 0;
    @(negedge clk);
    rst = 0;
    m_pc = 0;
    for (int i = 0; i < 64; i++) bht[i] = 1;
    fetch(32'h00500093, 19, 32'd5, 0, 0);
    flush_to(32'h10);
    fetch(32'hFE000EE3, 5, 32'hFFFFFFFC, 0, 0);
    fetch(32'h00500093, 19, 32'd5, 0, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
